led_scan_decoder: RTL

Receive-side counterpart of the 7-segment LED driver. It samples a multiplexed display bus (a one-hot digit select plus an 8-bit segment pattern) and requires each pattern to be stable before accepting it. It then decodes the pattern back to a hex nibble and rebuilds an 8-digit nibble array in the same layout as the driver's input array. It is used as a display-capture checker in simulation and as a board-level loopback monitor.

---
 rtl/led_scan_decoder.sv | 114 +++++++++++
 1 files changed

// File: rtl/led_scan_decoder.sv
// Capture side of a multiplexed 7-segment bus: waits for a stable one-hot select/segment
// pair, decodes the segment pattern back to a hex nibble and rebuilds the per-digit array.
module led_scan_decoder #(
    parameter int DIGITS        = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIGITS-1:0]     digitSel,
    input  logic [7:0]            segIn,
    input  logic                  clearErr,
    output logic [DIGITS*4-1:0]   dstArray,
    output logic [DIGITS-1:0]     digitValid,
    output logic [DIGITS-1:0]     digitErr,
    output logic                  frameDone
);

    localparam int          IW         = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [3:0]  CNT_MAX    = 4'(STABLE_CYCLES - 1);
    localparam logic [3:0]  CNT_COMMIT = 4'(STABLE_CYCLES - 2);

    logic [DIGITS-1:0]   prevSel_q;
    logic [7:0]          prevSeg_q;
    logic [3:0]          cnt_q, cnt_d;
    logic [DIGITS*4-1:0] dst_q, dst_d;
    logic [DIGITS-1:0]   valid_q, valid_d;
    logic [DIGITS-1:0]   err_q, err_d;
    logic                done_q, done_d;

    logic                onehot, match, commit;
    logic [IW-1:0]       sel_idx;
    logic                hit;
    logic [3:0]          nib;

    // {hit, nibble}: exact 8-bit match against the driver's code table
    function automatic logic [4:0] decode(input logic [7:0] s);
        case (s)
            8'h3F: decode = 5'h10;
            8'h06: decode = 5'h11;
            8'h5B: decode = 5'h12;
            8'h4F: decode = 5'h13;
            8'hE6: decode = 5'h14;
            8'hED: decode = 5'h15;
            8'hFD: decode = 5'h16;
            8'h27: decode = 5'h17;
            8'h7F: decode = 5'h18;
            8'h6F: decode = 5'h19;
            8'h77: decode = 5'h1A;
            8'h7C: decode = 5'h1B;
            8'h58: decode = 5'h1C;
            8'h5E: decode = 5'h1D;
            8'h79: decode = 5'h1E;
            8'h71: decode = 5'h1F;
            default: decode = 5'h00;
        endcase
    endfunction

    assign onehot = (digitSel != '0) && ((digitSel & (digitSel - DIGITS'(1))) == '0);
    assign match  = onehot && (digitSel == prevSel_q) && (segIn == prevSeg_q);
    // Counter saturates one above the commit value, so a long hold commits once only
    assign commit = match && (cnt_q == CNT_COMMIT);
    assign {hit, nib} = decode(segIn);

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < DIGITS; i++)
            if (digitSel[i]) sel_idx = IW'(i);
    end

    always_comb begin
        cnt_d   = '0;
        if (match) cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 4'd1;
        done_d  = &valid_q;
        valid_d = done_d ? '0 : valid_q;
        err_d   = clearErr ? '0 : err_q;
        dst_d   = dst_q;
        // A commit overrides both the frame clear and clearErr for its own digit
        if (commit) begin
            if (hit) begin
                dst_d[sel_idx*4 +: 4] = nib;
                valid_d[sel_idx]      = 1'b1;
                err_d[sel_idx]        = 1'b0;
            end else begin
                err_d[sel_idx]        = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prevSel_q <= '0;
            prevSeg_q <= '0;
            cnt_q     <= '0;
            dst_q     <= '0;
            valid_q   <= '0;
            err_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            prevSel_q <= digitSel;
            prevSeg_q <= segIn;
            cnt_q     <= cnt_d;
            dst_q     <= dst_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            done_q    <= done_d;
        end
    end

    assign dstArray   = dst_q;
    assign digitValid = valid_q;
    assign digitErr   = err_q;
    assign frameDone  = done_q;

endmodule
